// File: rtl/sr_readback_pkg.sv
//------------------------------------------------------------------------------
// sr_readback_pkg : shared state encodings and default widths for the
//                   shift-register write controller and sr_readback.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sr_readback_pkg;

  localparam int c_DATA_WIDTH_DEF = 170;
  localparam int c_CNT_WIDTH_DEF  = 8;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ARM   = 4'b0010,
    ST_SHIFT = 4'b0100,
    ST_DONE  = 4'b1000
  } sr_state_t;

endpackage

`default_nettype wire

// File: rtl/sr_popcount.sv
//------------------------------------------------------------------------------
// sr_popcount : counts the set bits of a vector.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sr_popcount
  import sr_readback_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = c_CNT_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] vector,
  output logic [CNT_WIDTH-1:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      count = count + CNT_WIDTH'(vector[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sr_readback.sv
//------------------------------------------------------------------------------
// sr_readback : serially reads back a shift register LSB-first and compares
//               the captured word against the last written word.
// Optional comparison logic: define SR_READBACK_CMP_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sr_readback
  import sr_readback_pkg::*;
#(
  parameter int DATA_WIDTH = c_DATA_WIDTH_DEF,
  parameter int CNT_WIDTH  = c_CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  dout_sr,
  input  logic [DATA_WIDTH-1:0] din_ref,
  output logic                  shift_en,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  mismatch,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  localparam logic [CNT_WIDTH-1:0] c_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  sr_state_t             r_state;
  logic [CNT_WIDTH-1:0]  r_count;
  logic [DATA_WIDTH-1:0] r_cap;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_cap   <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_ARM;
        end
        ST_ARM: begin
          r_count <= '0;
          r_cap   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          for (int i = 0; i < DATA_WIDTH; i++) begin
            if (r_count == CNT_WIDTH'(i)) r_cap[i] <= dout_sr;
          end
          // Counter parks at zero after the last bit so it never wraps.
          if (r_count == c_LAST) begin
            r_count <= '0;
            r_state <= ST_DONE;
          end else begin
            r_count <= r_count + CNT_WIDTH'(1);
          end
        end
        ST_DONE: begin
          r_dout  <= r_cap;
          r_valid <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign shift_en = (r_state == ST_SHIFT);
  assign busy     = (r_state != ST_IDLE);
  assign dout     = r_dout;
  assign valid    = r_valid;

`ifdef SR_READBACK_CMP_EN
  logic [CNT_WIDTH-1:0] w_diff_cnt;
  logic                 r_mismatch;
  logic [CNT_WIDTH-1:0] r_err_cnt;

  // Compare against the capture register so results land together with dout.
  sr_popcount #(
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_popcount (
    .vector (r_cap ^ din_ref),
    .count  (w_diff_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mismatch <= 1'b0;
      r_err_cnt  <= '0;
    end else if (r_state == ST_DONE) begin
      r_mismatch <= (r_cap != din_ref);
      r_err_cnt  <= w_diff_cnt;
    end
  end

  assign mismatch = r_mismatch;
  assign err_cnt  = r_err_cnt;
`else
  logic w_unused_din_ref;
  assign w_unused_din_ref = ^din_ref;
  assign mismatch         = 1'b0;
  assign err_cnt          = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sr_readback.sv
//------------------------------------------------------------------------------
// tb_sr_readback : self-checking bench for sr_readback at widths 8 and 170.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sr_readback;

  localparam int NS = 8;
  localparam int CS = 4;
  localparam int NW = 170;
  localparam int CW = 8;

`ifdef SR_READBACK_CMP_EN
  localparam bit c_CMP = 1'b1;
`else
  localparam bit c_CMP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance
  logic          rst_s, start_s, dout_sr_s, shift_en_s, busy_s, valid_s, mismatch_s;
  logic [NS-1:0] ref_s, dout_s, word_s;
  logic [CS-1:0] err_s;
  // wide instance
  logic          rst_w, start_w, dout_sr_w, shift_en_w, busy_w, valid_w, mismatch_w;
  logic [NW-1:0] ref_w, dout_w, word_w;
  logic [CW-1:0] err_w;

  sr_readback #(.DATA_WIDTH(NS), .CNT_WIDTH(CS)) u_dut_s (
    .clk(clk), .rst(rst_s), .start(start_s), .dout_sr(dout_sr_s), .din_ref(ref_s),
    .shift_en(shift_en_s), .busy(busy_s), .dout(dout_s), .valid(valid_s),
    .mismatch(mismatch_s), .err_cnt(err_s)
  );

  sr_readback #(.DATA_WIDTH(NW), .CNT_WIDTH(CW)) u_dut_w (
    .clk(clk), .rst(rst_w), .start(start_w), .dout_sr(dout_sr_w), .din_ref(ref_w),
    .shift_en(shift_en_w), .busy(busy_w), .dout(dout_w), .valid(valid_w),
    .mismatch(mismatch_w), .err_cnt(err_w)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit chk_on  = 1'b0;

  task automatic check_val(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a readback is a fixed timeline counted from start
  // acceptance; ph is cycles since acceptance (0 = idle). The model also plays
  // the shift register, presenting bit k of the accepted word before edge k+2.
  int            ph_s, ph_w;
  logic [NS-1:0] pend_s, m_dout_s;
  logic [NW-1:0] pend_w, m_dout_w;
  logic          junk_s, junk_w, m_valid_s, m_valid_w, m_mis_s, m_mis_w;
  logic [CS-1:0] m_err_s;
  logic [CW-1:0] m_err_w;

  always @(posedge clk or posedge rst_s) begin
    if (rst_s) begin
      ph_s <= 0; m_valid_s <= 1'b0; m_dout_s <= '0; m_mis_s <= 1'b0; m_err_s <= '0;
      pend_s <= '0; junk_s <= 1'b0;
    end else begin
      m_valid_s <= 1'b0;
      junk_s    <= 1'($urandom);
      if (ph_s == 0) begin
        if (start_s) begin ph_s <= 1; pend_s <= word_s; end
      end else if (ph_s == NS + 2) begin
        ph_s      <= 0;
        m_valid_s <= 1'b1;
        m_dout_s  <= pend_s;
        m_mis_s   <= c_CMP && (pend_s != ref_s);
        m_err_s   <= c_CMP ? CS'($countones(pend_s ^ ref_s)) : '0;
      end else begin
        ph_s <= ph_s + 1;
      end
    end
  end

  always @(posedge clk or posedge rst_w) begin
    if (rst_w) begin
      ph_w <= 0; m_valid_w <= 1'b0; m_dout_w <= '0; m_mis_w <= 1'b0; m_err_w <= '0;
      pend_w <= '0; junk_w <= 1'b0;
    end else begin
      m_valid_w <= 1'b0;
      junk_w    <= 1'($urandom);
      if (ph_w == 0) begin
        if (start_w) begin ph_w <= 1; pend_w <= word_w; end
      end else if (ph_w == NW + 2) begin
        ph_w      <= 0;
        m_valid_w <= 1'b1;
        m_dout_w  <= pend_w;
        m_mis_w   <= c_CMP && (pend_w != ref_w);
        m_err_w   <= c_CMP ? CW'($countones(pend_w ^ ref_w)) : '0;
      end else begin
        ph_w <= ph_w + 1;
      end
    end
  end

  assign dout_sr_s = (ph_s >= 2 && ph_s <= NS + 1) ? pend_s[ph_s-2] : junk_s;
  assign dout_sr_w = (ph_w >= 2 && ph_w <= NW + 1) ? pend_w[ph_w-2] : junk_w;

  always @(negedge clk) begin
    if (chk_on) begin
      check_val("s_busy",     busy_s,     ph_s != 0);
      check_val("s_shift_en", shift_en_s, ph_s >= 2 && ph_s <= NS + 1);
      check_val("s_valid",    valid_s,    m_valid_s);
      check_val("s_dout",     dout_s,     m_dout_s);
      check_val("s_mismatch", mismatch_s, m_mis_s);
      check_val("s_err_cnt",  err_s,      m_err_s);
      check_val("w_busy",     busy_w,     ph_w != 0);
      check_val("w_shift_en", shift_en_w, ph_w >= 2 && ph_w <= NW + 1);
      check_val("w_valid",    valid_w,    m_valid_w);
      check_val("w_dout",     dout_w,     m_dout_w);
      check_val("w_mismatch", mismatch_w, m_mis_w);
      check_val("w_err_cnt",  err_w,      m_err_w);
    end
  end

  function automatic logic [NW-1:0] rand_w();
    logic [191:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[NW-1:0];
  endfunction

  // Raise start for one edge, then count edges until valid is seen.
  task automatic run_s(input logic [NS-1:0] w, input logic [NS-1:0] r, output int n);
    bit seen;
    word_s = w; ref_s = r; start_s = 1'b1;
    n = 0; seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(posedge clk); #1 start_s = 1'b0;
      n++;
      @(negedge clk);
      if (valid_s) seen = 1'b1;
    end
    if (!seen) check_val("s_valid_timeout", 0, 1);
  endtask

  task automatic check_zero_s(input string tag);
    check_val({tag, "_busy"},     busy_s,     0);
    check_val({tag, "_shift_en"}, shift_en_s, 0);
    check_val({tag, "_valid"},    valid_s,    0);
    check_val({tag, "_dout"},     dout_s,     0);
    check_val({tag, "_mismatch"}, mismatch_s, 0);
    check_val({tag, "_err_cnt"},  err_s,      0);
  endtask

  initial begin
    int n, cnt, last;
    bit seen;
    logic [NW-1:0] walk;

    rst_s = 1'b1; rst_w = 1'b1; start_s = 1'b0; start_w = 1'b0;
    word_s = '0; ref_s = '0; word_w = '0; ref_w = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_s("rst_s");
    check_val("rst_w_busy", busy_w, 0);
    check_val("rst_w_dout", dout_w, 0);
    check_val("rst_w_valid", valid_w, 0);
    chk_on = 1'b1;
    rst_s = 1'b0; rst_w = 1'b0;
    @(posedge clk); #1;

    // nominal match
    run_s(8'hA5, 8'hA5, n);
    check_val("nom_latency", n, 11);
    check_val("nom_dout", dout_s, 8'hA5);
    check_val("nom_mismatch", mismatch_s, 0);
    check_val("nom_err_cnt", err_s, 0);
    @(posedge clk); #1;

    // single-bit mismatch
    run_s(8'hA4, 8'hA5, n);
    check_val("mis_dout", dout_s, 8'hA4);
    check_val("mis_mismatch", mismatch_s, c_CMP);
    check_val("mis_err_cnt", err_s, c_CMP ? 1 : 0);
    @(posedge clk); #1;

    // start while busy: second pulse three cycles into SHIFT is dropped
    word_s = 8'h3C; start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    repeat (4) @(posedge clk);
    #1 start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (valid_s) begin
        cnt++;
        check_val("busy_start_busy_low", busy_s, 0);
        check_val("busy_start_dout", dout_s, 8'h3C);
      end
    end
    check_val("busy_start_valid_count", cnt, 1);
    @(posedge clk); #1;

    // reset at bit 4 of 8
    word_s = 8'h5A; start_s = 1'b1;
    @(posedge clk); #1 start_s = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst_s = 1'b1;
    #1 check_zero_s("midrst");
    @(posedge clk); #1 rst_s = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (valid_s) cnt++;
    end
    check_val("midrst_no_valid", cnt, 0);
    @(posedge clk); #1;
    run_s(8'h5A, 8'hA5, n);
    check_val("midrst_after_latency", n, 11);
    check_val("midrst_after_dout", dout_s, 8'h5A);
    @(posedge clk); #1;

    // back-to-back with start held high
    start_s = 1'b1; cnt = 0; last = -1;
    for (int k = 0; k < 70; k++) begin
      word_s = NS'($urandom);
      @(negedge clk);
      if (valid_s) begin
        if (last >= 0) check_val("b2b_period", k - last, 11);
        last = k;
        cnt++;
      end
      @(posedge clk); #1;
    end
    start_s = 1'b0;
    check_val("b2b_pulses", cnt >= 5, 1);
    repeat (15) @(posedge clk);
    #1;

    // full width walking one at bit 169
    walk = '0; walk[NW-1] = 1'b1;
    word_w = walk; ref_w = rand_w(); start_w = 1'b1;
    @(posedge clk); #1 start_w = 1'b0;
    cnt = 0; seen = 1'b0;
    for (int k = 0; k < 220 && !seen; k++) begin
      @(negedge clk);
      if (shift_en_w) cnt++;
      if (valid_w) seen = 1'b1;
    end
    if (!seen) check_val("w_valid_timeout", 0, 1);
    check_val("w_shift_cycles", cnt, 170);
    check_val("w_dout_walk", dout_w, walk);
    @(posedge clk); #1;

    // randomized traffic on both instances
    for (int k = 0; k < 1500; k++) begin
      start_s = ($urandom % 4) == 0;
      word_s  = NS'($urandom);
      if (ph_s == 0) ref_s = NS'($urandom);
      start_w = ($urandom % 16) == 0;
      word_w  = rand_w();
      if (ph_w == 0) ref_w = (($urandom % 2) == 0) ? word_w : rand_w();
      @(posedge clk); #1;
    end
    start_s = 1'b0; start_w = 1'b0;
    repeat (200) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
